// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO reader: default data width, FSM state
// encoding and the statistics counter width plus its saturating increment.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int STATS_W        = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_POLL    = 2'd1,
        ST_BACKOFF = 2'd2
    } state_e;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v,
                                                   input logic               inc);
        if (inc && (v != {STATS_W{1'b1}})) begin
            return v + STATS_W'(1);
        end
        return v;
    endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// Circular output buffer for the FIFO reader: push/pop with wrap-around
// pointers, head word presented combinationally from the storage flops.
module fifo_reader_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        head_data,
    output logic                         empty,
    output logic [$clog2(BUF_DEPTH):0]   count
);

    localparam int            AW       = $clog2(BUF_DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  do_push, do_pop;
    logic                  full;

    always_comb begin
        full    = (count_q == FULL_CNT);
        do_pop  = pop && (count_q != '0);
        do_push = push && (!full || do_pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head is forced to zero when empty so the downstream bus idles at 0.
    assign empty     = (count_q == '0);
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fifo_reader.sv
// FIFO reader: polls an upstream registered-read FIFO under a credit limit,
// backs off after underflow, and streams words out through fifo_reader_buf.
// Optional statistics outputs are enabled with `define FIFO_READER_STATS_EN.
//
// Downstream handshake: a word moves on a rising edge where m_valid && m_ready;
// m_valid never drops and m_data never changes while m_valid && !m_ready.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUF_DEPTH  = 4,
    parameter int BACKOFF    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic                  rd_n,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  under_flow,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output state_e                dbg_state
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [STATS_W-1:0]    uf_count,
    output logic [STATS_W-1:0]    rd_count
`endif
);

    localparam int              AW         = $clog2(BUF_DEPTH);
    localparam logic [AW+1:0]   DEPTH_C    = (AW+2)'(BUF_DEPTH);
    localparam logic [3:0]      BACKOFF_LD = 4'(BACKOFF);

    state_e      state_q, state_d;
    logic        rd_n_q, rd_n_d;
    logic        pend_q, pend_d;
    logic [3:0]  bo_cnt_q, bo_cnt_d;

    logic [AW:0]   buf_count;
    logic          buf_empty;
    logic          ret_ok, ret_uf;
    logic          pop;
    logic [AW+1:0] credit_sum;
    logic          credit_ok;

    // pend_q marks a cycle whose fifo_data/under_flow answer last edge's read.
    always_comb begin
        ret_ok     = pend_q && !under_flow;
        ret_uf     = pend_q && under_flow;
        pop        = !buf_empty && m_ready;
        // Counts the word returning now and the read the FIFO is sampling now,
        // so a newly issued read always finds a free slot when it lands.
        credit_sum = {1'b0, buf_count}
                   + {{(AW+1){1'b0}}, pend_q}
                   + {{(AW+1){1'b0}}, ~rd_n_q};
        credit_ok  = (credit_sum < DEPTH_C);
    end

    always_comb begin
        state_d  = state_q;
        rd_n_d   = 1'b1;
        bo_cnt_d = bo_cnt_q;
        pend_d   = ~rd_n_q;

        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_POLL;
                    rd_n_d  = ~credit_ok;
                end
            end
            ST_POLL: begin
                if (ret_uf) begin
                    state_d  = ST_BACKOFF;
                    bo_cnt_d = BACKOFF_LD;
                end else if (!en) begin
                    state_d = ST_IDLE;
                end else begin
                    rd_n_d = ~credit_ok;
                end
            end
            ST_BACKOFF: begin
                // Later underflow answers are ignored here: the count runs on.
                if (bo_cnt_q <= 4'd1) begin
                    bo_cnt_d = 4'd0;
                    if (en) begin
                        state_d = ST_POLL;
                        rd_n_d  = ~credit_ok;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    bo_cnt_d = bo_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                bo_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rd_n_q   <= 1'b1;
            pend_q   <= 1'b0;
            bo_cnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            rd_n_q   <= rd_n_d;
            pend_q   <= pend_d;
            bo_cnt_q <= bo_cnt_d;
        end
    end

    fifo_reader_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (ret_ok),
        .push_data  (fifo_data),
        .pop        (pop),
        .head_data  (m_data),
        .empty      (buf_empty),
        .count      (buf_count)
    );

    assign rd_n      = rd_n_q;
    assign m_valid   = ~buf_empty;
    assign busy      = (state_q != ST_IDLE) || pend_q || !rd_n_q;
    assign dbg_state = state_q;

`ifdef FIFO_READER_STATS_EN
    logic [STATS_W-1:0] uf_cnt_q, uf_cnt_d;
    logic [STATS_W-1:0] rd_cnt_q, rd_cnt_d;

    always_comb begin
        uf_cnt_d = sat_inc(uf_cnt_q, ret_uf);
        rd_cnt_d = sat_inc(rd_cnt_q, ret_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uf_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            uf_cnt_q <= uf_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign uf_count = uf_cnt_q;
    assign rd_count = rd_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: directed vector table, multi-cycle corner sequences
// and a randomized run scored against a queue model of the upstream FIFO.
`timescale 1ns/1ps
module tb_fifo_reader;
  import fifo_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int BO    = 4;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b1;
  logic          en         = 1'b0;
  logic          m_ready    = 1'b0;
  logic          under_flow = 1'b0;
  logic [DW-1:0] fifo_data  = '0;
  logic          rd_n;
  logic          m_valid;
  logic          busy;
  logic [DW-1:0] m_data;
  state_e        dbg_state;
`ifdef FIFO_READER_STATS_EN
  logic [15:0]   uf_count;
  logic [15:0]   rd_count;
`endif

  fifo_reader #(
    .DATA_WIDTH (DW),
    .BUF_DEPTH  (DEPTH),
    .BACKOFF    (BO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .rd_n       (rd_n),
    .fifo_data  (fifo_data),
    .under_flow (under_flow),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy)
    ,.dbg_state (dbg_state)
`ifdef FIFO_READER_STATS_EN
    ,.uf_count  (uf_count)
    ,.rd_count  (rd_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // model state
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  logic          rd_seen    = 1'b0;
  int            uf_seen    = 0;
  int            xfer_cnt   = 0;
  int            rd_low_cnt = 0;
  int            first_xfer = 0;
  int            last_xfer  = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en      = 1'b0;
    m_ready = 1'b0;
    rst_n   = 1'b0;
    exp_q.delete();
    src_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    xfer_cnt   = 0;
    rd_low_cnt = 0;
    uf_seen    = 0;
  endtask

  // Mid-cycle monitor/scoreboard followed by the upstream FIFO responder.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        total++;
        a_reset: assert (rd_n && !m_valid && (m_data == '0) && !busy && (dbg_state == ST_IDLE))
          else begin
            bad++;
            $display("FAIL reset_vals: rd_n=%0b m_valid=%0b m_data=%0d busy=%0b state=%0d",
                     rd_n, m_valid, m_data, busy, dbg_state);
          end
        prev_stall = 1'b0;
        rd_seen    = 1'b0;
        fifo_data  = '0;
        under_flow = 1'b0;
      end else begin
        if (prev_stall) begin
          total++;
          a_stable: assert (m_valid && (m_data == prev_data))
            else begin
              bad++;
              $display("FAIL stall_stable: m_valid=%0b m_data=%0d required 1/%0d", m_valid, m_data, prev_data);
            end
        end
        if (dbg_state != ST_POLL) begin
          total++;
          a_rdn_quiet: assert (rd_n)
            else begin
              bad++;
              $display("FAIL rd_n_quiet: rd_n=0 in state %0d", dbg_state);
            end
        end
        total++;
        a_buf_bound: assert (int'(dut.buf_count) <= DEPTH)
          else begin
            bad++;
            $display("FAIL buf_bound: count=%0d limit=%0d", dut.buf_count, DEPTH);
          end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("xfer_unexpected", int'(m_data), -1);
          end else begin
            e = exp_q.pop_front();
            chk("xfer_data", int'(m_data), int'(e));
          end
          if (xfer_cnt == 0) first_xfer = cyc;
          last_xfer = cyc;
          xfer_cnt++;
        end
        if (!rd_n) rd_low_cnt++;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;

        // Responder: a read seen last cycle is answered now, sampled at the next edge.
        if (rd_seen) begin
          if (src_q.size() > 0) begin
            fifo_data  = src_q.pop_front();
            under_flow = 1'b0;
            exp_q.push_back(fifo_data);
          end else begin
            fifo_data  = DW'($urandom);
            under_flow = 1'b1;
            uf_seen++;
          end
        end else begin
          fifo_data  = DW'($urandom);
          under_flow = 1'($urandom);
        end
        rd_seen = !rd_n;
      end
    end
  end

  typedef struct {
    int preload;
    int stall;
    int exp_reads;
    int exp_xfer;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int w;
    int hi;

    vecs[0] = '{preload: 16, stall: 10, exp_reads: DEPTH, exp_xfer: 16};
    vecs[1] = '{preload: 4,  stall: 10, exp_reads: DEPTH, exp_xfer: 4};
    vecs[2] = '{preload: 8,  stall: 12, exp_reads: DEPTH, exp_xfer: 8};
    vecs[3] = '{preload: 5,  stall: 6,  exp_reads: DEPTH, exp_xfer: 5};

    // power-on reset
    #2 rst_n = 1'b0;
    #1;
    chk("por_rd_n", int'(rd_n), 1);
    chk("por_m_valid", int'(m_valid), 0);
    chk("por_m_data", int'(m_data), 0);
    chk("por_busy", int'(busy), 0);
    chk("por_state", int'(dbg_state), int'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(4);
    chk("post_rst_junk_ignored", int'(m_valid), 0);
    chk("post_rst_busy", int'(busy), 0);

    // backpressure table
    for (int i = 0; i < 4; i++) begin
      do_reset();
      for (int k = 0; k < vecs[i].preload; k++) src_q.push_back(DW'(64 + i * 16 + k));
      m_ready = 1'b0;
      en      = 1'b1;
      tick(vecs[i].stall);
      chk($sformatf("vec%0d_reads", i), rd_low_cnt, vecs[i].exp_reads);
      chk($sformatf("vec%0d_held", i), exp_q.size(), vecs[i].exp_reads);
      chk($sformatf("vec%0d_rd_n_high", i), int'(rd_n), 1);
      m_ready = 1'b1;
      w = 0;
      while (xfer_cnt < vecs[i].exp_xfer && w < 200) begin
        tick(1);
        w++;
      end
      chk($sformatf("vec%0d_xfer", i), xfer_cnt, vecs[i].exp_xfer);
      en = 1'b0;
      tick(10);
      chk($sformatf("vec%0d_drained", i), exp_q.size(), 0);
    end

    // streaming: 16 words, one per cycle after the first
    do_reset();
    for (int k = 0; k < 16; k++) src_q.push_back(DW'(k));
    m_ready = 1'b1;
    en      = 1'b1;
    w = 0;
    while (xfer_cnt < 16 && w < 200) begin
      tick(1);
      w++;
    end
    chk("stream_xfer", xfer_cnt, 16);
    chk("stream_rate", last_xfer - first_xfer, 15);
`ifdef FIFO_READER_STATS_EN
    chk("stream_rd_count", int'(rd_count), 16);
`endif
    en = 1'b0;
    tick(12);

    // underflow and backoff
    do_reset();
    m_ready = 1'b1;
    en      = 1'b1;
    w = 0;
    while (uf_seen == 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    chk("uf_returned", int'(uf_seen > 0), 1);
    hi = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rd_n) hi++;
      else break;
    end
    chk("backoff_len", hi, BO);
    chk("repoll", int'(rd_n), 0);
    chk("uf_no_data", xfer_cnt, 0);
`ifdef FIFO_READER_STATS_EN
    chk("uf_count", int'(uf_count), 2);
`endif
    #1;
    en = 1'b0;
    tick(12);

    // en dropped in the cycle the read is issued
    do_reset();
    for (int k = 0; k < 4; k++) src_q.push_back(DW'(192 + k));
    m_ready = 1'b1;
    en      = 1'b1;
    @(posedge clk);
    #1;
    chk("dis_read_issued", int'(rd_n), 0);
    en = 1'b0;
    tick(10);
    chk("dis_xfer", xfer_cnt, 1);
    chk("dis_src_left", src_q.size(), 3);
    chk("dis_state", int'(dbg_state), int'(ST_IDLE));
    chk("dis_busy", int'(busy), 0);
    chk("dis_m_valid", int'(m_valid), 0);

    // reset mid-stream with three words buffered
    do_reset();
    for (int k = 0; k < 3; k++) src_q.push_back(DW'(160 + k));
    m_ready = 1'b0;
    en      = 1'b1;
    tick(12);
    chk("rst_buffered", exp_q.size(), 3);
    chk("rst_pre_valid", int'(m_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_rd_n", int'(rd_n), 1);
    chk("rst_m_data", int'(m_data), 0);
    exp_q.delete();
    src_q.delete();
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    en       = 1'b0;
    m_ready  = 1'b1;
    xfer_cnt = 0;
    tick(6);
    chk("rst_no_stale", xfer_cnt, 0);
    chk("rst_idle_valid", int'(m_valid), 0);

    // randomized traffic against the queue model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      en      = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && src_q.size() < 8) src_q.push_back(DW'($urandom));
      tick(1);
    end
    en      = 1'b0;
    m_ready = 1'b1;
    tick(25);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_m_valid", int'(m_valid), 0);
    chk("rand_busy", int'(busy), 0);
    chk("rand_state", int'(dbg_state), int'(ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, FIFO data bus width.
REQ-002 SHALL have parameter BUF_DEPTH, default 4, output buffer entries (power of two, >=2).
REQ-003 SHALL have parameter BACKOFF, default 4, idle cycles after an underflow before polling resumes (1..15).
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  poll enable.
REQ-007 rd_n  output  1  FIFO read strobe, active-low, driven directly from a flop.
REQ-008 fifo_data  input  DATA_WIDTH  FIFO registered read data, valid one cycle after rd_n sampled low.
REQ-009 under_flow  input  1  FIFO underflow flag, same timing as fifo_data.
REQ-010 m_data  output  DATA_WIDTH  downstream data.
REQ-011 m_valid  output  1  downstream valid.
REQ-012 m_ready  input  1  downstream ready; transfer when m_valid && m_ready.
REQ-013 busy  output  1  high when state != IDLE or a read is outstanding.

Function
REQ-014 Read timing: rd_n low at edge E means the return (fifo_data, under_flow) SHALL be sampled at edge E+1.
REQ-015 Return with under_flow=0 SHALL be pushed into the buffer at E+1; m_valid SHALL be high in the cycle after E+1 if the buffer was empty.
REQ-016 Return with under_flow=1 SHALL be discarded, never pushed.
REQ-017 Credit rule: rd_n SHALL be driven low for a cycle only if buffer count plus outstanding reads (including the one returning that cycle) < BUF_DEPTH; the buffer SHALL never overflow.
REQ-018 With m_ready held high and the FIFO never empty, one word per cycle SHALL be sustained after initial latency.
REQ-019 FSM states IDLE, POLL, BACKOFF.
REQ-020 IDLE->POLL when en=1; rd_n SHALL stay high in IDLE.
REQ-021 POLL->BACKOFF on a sampled return with under_flow=1; backoff counter loaded with BACKOFF.
REQ-022 BACKOFF: rd_n high, counter decrements each cycle; ->POLL at zero if en=1, else ->IDLE.
REQ-023 POLL->IDLE when en=0; a read already issued SHALL still be sampled and handled per REQ-015/016.
REQ-024 Underflow return while a second read is outstanding: second return SHALL be handled normally (valid data still pushed); backoff counter not restarted by a second underflow in BACKOFF.
REQ-025 Buffer is a circular FIFO with wrap-around pointers; simultaneous push and pop SHALL leave count unchanged; data order preserved.
REQ-026 m_data/m_valid SHALL be stable while m_valid=1 and m_ready=0.

Reset
REQ-027 On rst_n low, immediately: rd_n=1, m_valid=0, m_data=0, busy=0, state=IDLE, buffer count/pointers=0, outstanding=0, backoff counter=0.
REQ-028 A return arriving in the first edge after reset release SHALL be ignored (outstanding cleared by reset).

Configuration
REQ-029 Macro FIFO_READER_STATS_EN: when defined, add outputs uf_count (16 bits, saturating count of discarded underflow returns) and rd_count (16 bits, saturating count of words pushed), both reset to 0; when undefined, these ports and counters SHALL not exist and behaviour is otherwise identical.

Structure
REQ-030 Shared package fifo_pkg SHALL hold DATA_WIDTH default, the FSM state enum (IDLE/POLL/BACKOFF) and the stats counter width.
REQ-031 Output buffer SHALL be sub-module fifo_reader_buf (push/pop/count interface); FSM, credit logic and stats in fifo_reader.

Verification
REQ-032 Bench SHALL include embedded assertions for: reset values, buffer never exceeds BUF_DEPTH, rd_n high in IDLE/BACKOFF, m_data stability under stall.
REQ-033 Reset: rst_n low mid-stream with 3 words buffered -> m_valid=0, rd_n=1 same cycle; no stale word after release.
REQ-034 Streaming: FIFO preloaded with 16 bytes 0x00..0x0F, en=1, m_ready=1 -> 16 transfers in order, one per cycle after first.
REQ-035 Backpressure: m_ready=0 for 10 cycles with FIFO full -> exactly BUF_DEPTH (4) words buffered, rd_n high thereafter, no loss on resume.
REQ-036 Underflow: empty FIFO, en=1 -> one read, under_flow=1 returned, rd_n high for exactly BACKOFF (4) cycles, then polls again; uf_count increments (stats build).
REQ-037 Disable: en dropped the cycle a read is issued -> return still delivered, state IDLE, busy low after buffer drains.
